uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised, oversampling UART receiver: the next generation of the fixed 8N1 bit-clocked receiver. It runs on the system clock with a baud-tick enable, adds mid-bit sampling, false-start rejection, configurable data width, parity and stop bits, and error flags. Received words are presented on a valid/ready handshake with overrun detection. It sits between the rx pin and any byte consumer (FIFO, command decoder).

## Interface
- DATA_BITS, 8: data bits per frame, 5..9, LSB first
- OVERSAMPLE, 16: baud_tick pulses per bit period, even, 4..64
- PARITY, 0: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1: 1 or 2

- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-high
- baud_tick  in  1  one-cycle enable at OVERSAMPLE × baud rate
- rx  in  1  serial line, asynchronous, idle high
- data  out  DATA_BITS  received word, valid while data_valid
- data_valid  out  1  word available
- data_ready  in  1  consumer accepts word when data_valid && data_ready
- parity_err  out  1  parity mismatch for the presented word (0 when PARITY = 0)
- frame_err  out  1  a stop bit was sampled low for the presented word
- overrun  out  1  one-cycle pulse: completed frame dropped
- busy  out  1  FSM not in IDLE

## Operation
- rx passes through a 2-flop synchroniser (reset value 1); all logic uses rx_s.
- Tick counter width is clog2(OVERSAMPLE). The FSM and counters advance only on baud_tick cycles.
- IDLE: on rx_s == 0, clear the tick counter and go to START.
- START: after OVERSAMPLE/2 ticks (mid-bit), resample rx_s. If 1, this is a false start: return to IDLE, nothing output. If 0, go to DATA with bit index 0.
- DATA: every OVERSAMPLE ticks, sample rx_s into shift bit [index]. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
- PARITY: one sample. parity_err_next = (XOR of data bits ^ sample) for even, or its inverse for odd.
- STOP: sample STOP_BITS times, one bit period apart. frame_err_next is set if any stop sample is 0.
  - After the last stop sample, complete the frame. Go to IDLE if frame_err_next = 0, else to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1 (break or line-low protection), then IDLE.
- Frame completion loads data, parity_err and frame_err, and sets data_valid, when data_valid == 0 or the current word is accepted in the same cycle.
  - Otherwise the new frame is discarded, the old word and flags are held, and overrun pulses for 1 cycle.
- Acceptance (data_valid && data_ready) without a new completion clears data_valid. data, parity_err and frame_err hold their last values.
- Frames with errors are still delivered. A break (all-zero data, frame_err = 1) is delivered once.

## Timing
- Reset (async assert, applied immediately): data = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, FSM = IDLE, synchroniser = 1. Reset mid-frame abandons the frame and outputs nothing.
- Start-edge detection lags the rx pin by 2 clocks (synchroniser).
- data_valid rises on the clock edge after the baud_tick that takes the last stop sample. That is the mid-point of the last stop bit, giving 0.5 bit of re-arm margin for back-to-back frames.
- busy drops in the same cycle the FSM re-enters IDLE.
- data_ready is combinationally sampled. There is no combinational path from data_ready to any output.
- baud_tick held high is legal: 1 tick per clock.

## Test plan
All cases use baud_tick = 1 and OVERSAMPLE = 16 (bit = 16 clocks) unless noted.
- 8N1, rx frame 0xA5, data_ready = 1 -> data = 0xA5, data_valid pulses 1 cycle, parity_err = frame_err = 0, busy low afterwards.
- rx low pulse of 4 clocks then high -> START rejects at mid-bit, no data_valid, busy returns to 0 within 10 clocks.
- PARITY = 1, frame 0x03 with parity bit 1 (incorrect) -> data = 0x03, parity_err = 1. Same frame with parity 0 -> parity_err = 0.
- STOP_BITS = 2, frame 0x7E with second stop bit 0, rx then held low 40 bits -> one word 0x7E, frame_err = 1, busy stays 1 until rx high, no further frames.
- data_ready = 0, back-to-back frames 0x11, 0x22 -> data stays 0x11 with data_valid held, overrun pulses exactly 1 cycle. Raising data_ready accepts 0x11 and data_valid falls.
- Assert rst mid-data of frame 0x3C -> all outputs 0 asynchronously and no word delivered. A subsequent frame 0x5A -> data = 0x5A with no errors.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with optional parity, 1/2 stop bits,
// error flags and a valid/ready output with overrun detection.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;
    state_t state;
    logic rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    logic stop_i;
    logic [DATA_BITS-1:0] shift;
    logic par_n, fe_n;
    logic full_bit, last_stop, complete, accept, take, fe_fin;

    assign full_bit  = cnt == CW'(OVERSAMPLE - 1);
    assign last_stop = stop_i == 1'(STOP_BITS - 1);
    assign complete  = baud_tick && state == STOP && full_bit && last_stop;
    assign accept    = data_valid && data_ready;
    assign take      = !data_valid || data_ready;
    assign fe_fin    = fe_n | ~rx_s;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Data bits shift in from the MSB so the first (LSB) bit lands at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            stop_i <= 1'b0;
            shift  <= '0;
            par_n  <= 1'b0;
            fe_n   <= 1'b0;
        end else if (baud_tick) begin
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: if (!rx_s) begin
                    cnt    <= '0;
                    idx    <= '0;
                    stop_i <= 1'b0;
                    par_n  <= 1'b0;
                    fe_n   <= 1'b0;
                    state  <= START;
                end
                START: if (cnt == CW'(OVERSAMPLE / 2 - 1)) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : DATA;
                end
                DATA: if (full_bit) begin
                    cnt   <= '0;
                    shift <= {rx_s, shift[DATA_BITS-1:1]};
                    idx   <= idx + 4'd1;
                    if (idx == 4'(DATA_BITS - 1))
                        state <= (PARITY != 0) ? PAR : STOP;
                end
                PAR: if (full_bit) begin
                    cnt   <= '0;
                    par_n <= ^shift ^ rx_s ^ (PARITY == 2);
                    state <= STOP;
                end
                STOP: if (full_bit) begin
                    cnt    <= '0;
                    fe_n   <= fe_fin;
                    stop_i <= 1'b1;
                    if (last_stop)
                        state <= fe_fin ? WAIT_IDLE : IDLE;
                end
                WAIT_IDLE: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= complete && !take;
            if (complete && take) begin
                data       <= shift;
                parity_err <= par_n;
                frame_err  <= fe_fin;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed checks of three receiver configurations (8N1, 8E1, 8N2)
// sharing one rx line, with baud_tick held high and 16x oversampling.
module tb_uart_rx_os;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b1;
    logic rx = 1'b1;
    logic data_ready = 1'b1;
    logic [7:0] data0, data1, data2;
    logic dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, busy0, busy1, busy2;
    int vectors = 0;
    int errs = 0;
    int dv0_n = 0, dv1_n = 0, dv2_n = 0, ov0_n = 0;

    uart_rx_os u0 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx), .data(data0),
                   .data_valid(dv0), .data_ready(data_ready), .parity_err(pe0),
                   .frame_err(fe0), .overrun(ov0), .busy(busy0));
    uart_rx_os #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
                   .data(data1), .data_valid(dv1), .data_ready(data_ready), .parity_err(pe1),
                   .frame_err(fe1), .overrun(ov1), .busy(busy1));
    uart_rx_os #(.STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
                   .data(data2), .data_valid(dv2), .data_ready(data_ready), .parity_err(pe2),
                   .frame_err(fe2), .overrun(ov2), .busy(busy2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        dv0_n = dv0_n + (dv0 ? 1 : 0);
        dv1_n = dv1_n + (dv1 ? 1 : 0);
        dv2_n = dv2_n + (dv2 ? 1 : 0);
        ov0_n = ov0_n + (ov0 ? 1 : 0);
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++; if (data0 !== 8'h00) begin errs++; $display("FAIL reset_data: got %h expected 00", data0); end
        vectors++; if (dv0 !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", dv0); end
        vectors++; if (pe0 !== 1'b0 || fe0 !== 1'b0) begin errs++; $display("FAIL reset_errs: got pe=%b fe=%b expected 0 0", pe0, fe0); end
        vectors++; if (ov0 !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b expected 0", ov0); end
        vectors++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (busy0 !== 1'b0 || dv0 !== 1'b0) begin errs++; $display("FAIL idle_after_reset: got busy=%b dv=%b expected 0 0", busy0, dv0); end
    endtask

    task automatic test_basic;
        int b;
        b = dv0_n;
        send_data(8'hA5);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (dv0_n - b !== 1) begin errs++; $display("FAIL basic_valid_cycles: got %0d expected 1", dv0_n - b); end
        vectors++; if (data0 !== 8'hA5) begin errs++; $display("FAIL basic_data: got %h expected a5", data0); end
        vectors++; if (pe0 !== 1'b0 || fe0 !== 1'b0) begin errs++; $display("FAIL basic_errs: got pe=%b fe=%b expected 0 0", pe0, fe0); end
        vectors++; if (busy0 !== 1'b0 || dv0 !== 1'b0) begin errs++; $display("FAIL basic_after: got busy=%b dv=%b expected 0 0", busy0, dv0); end
    endtask

    task automatic test_false_start;
        int b;
        b = dv0_n;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (busy0 !== 1'b1) begin errs++; $display("FAIL false_start_busy: got %b expected 1", busy0); end
        rx = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (busy0 !== 1'b0) begin errs++; $display("FAIL false_start_idle: got %b expected 0", busy0); end
        repeat (40) @(negedge clk);
        vectors++; if (dv0_n !== b) begin errs++; $display("FAIL false_start_word: got %0d words expected 0", dv0_n - b); end
    endtask

    task automatic test_parity;
        int b;
        b = dv1_n;
        send_data(8'h03);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (data1 !== 8'h03) begin errs++; $display("FAIL parity_bad_data: got %h expected 03", data1); end
        vectors++; if (pe1 !== 1'b1 || fe1 !== 1'b0) begin errs++; $display("FAIL parity_bad_flags: got pe=%b fe=%b expected 1 0", pe1, fe1); end
        send_data(8'h03);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (data1 !== 8'h03 || pe1 !== 1'b0) begin errs++; $display("FAIL parity_good: got data=%h pe=%b expected 03 0", data1, pe1); end
        vectors++; if (dv1_n - b !== 2) begin errs++; $display("FAIL parity_words: got %0d expected 2", dv1_n - b); end
        repeat (48) @(negedge clk);
    endtask

    task automatic test_stop2;
        int b;
        b = dv2_n;
        send_data(8'h7E);
        send_bit(1'b1);
        rx = 1'b0;
        repeat (32) @(negedge clk);
        vectors++; if (data2 !== 8'h7E || fe2 !== 1'b1 || pe2 !== 1'b0) begin errs++; $display("FAIL stop2_word: got data=%h fe=%b pe=%b expected 7e 1 0", data2, fe2, pe2); end
        repeat (38 * 16) @(negedge clk);
        vectors++; if (busy2 !== 1'b1) begin errs++; $display("FAIL stop2_busy_low: got %b expected 1", busy2); end
        vectors++; if (dv2_n - b !== 1) begin errs++; $display("FAIL stop2_words_low: got %0d expected 1", dv2_n - b); end
        rx = 1'b1;
        repeat (32) @(negedge clk);
        vectors++; if (busy2 !== 1'b0) begin errs++; $display("FAIL stop2_busy_high: got %b expected 0", busy2); end
        vectors++; if (dv2_n - b !== 1) begin errs++; $display("FAIL stop2_words_end: got %0d expected 1", dv2_n - b); end
        repeat (32) @(negedge clk);
    endtask

    task automatic test_overrun;
        int b;
        data_ready = 1'b0;
        b = ov0_n;
        send_data(8'h11);
        send_bit(1'b1);
        send_data(8'h22);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (data0 !== 8'h11 || dv0 !== 1'b1) begin errs++; $display("FAIL overrun_hold: got data=%h dv=%b expected 11 1", data0, dv0); end
        vectors++; if (ov0_n - b !== 1) begin errs++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov0_n - b); end
        data_ready = 1'b1;
        @(negedge clk);
        vectors++; if (dv0 !== 1'b0) begin errs++; $display("FAIL overrun_accept: got dv=%b expected 0", dv0); end
        vectors++; if (data0 !== 8'h11 || pe0 !== 1'b0 || fe0 !== 1'b0) begin errs++; $display("FAIL overrun_data_hold: got data=%h pe=%b fe=%b expected 11 0 0", data0, pe0, fe0); end
        repeat (32) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int b;
        b = dv0_n;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        vectors++; if (busy0 !== 1'b1) begin errs++; $display("FAIL midrst_busy_before: got %b expected 1", busy0); end
        rst = 1'b1;
        #1;
        vectors++; if (data0 !== 8'h00 || dv0 !== 1'b0) begin errs++; $display("FAIL midrst_async: got data=%h dv=%b expected 00 0", data0, dv0); end
        vectors++; if (busy0 !== 1'b0 || pe0 !== 1'b0 || fe0 !== 1'b0 || ov0 !== 1'b0) begin errs++; $display("FAIL midrst_flags: got busy=%b pe=%b fe=%b ov=%b expected 0 0 0 0", busy0, pe0, fe0, ov0); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (48) @(negedge clk);
        vectors++; if (dv0_n !== b || data0 !== 8'h00) begin errs++; $display("FAIL midrst_no_word: got words=%0d data=%h expected 0 00", dv0_n - b, data0); end
        send_data(8'h5A);
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        vectors++; if (data0 !== 8'h5A || pe0 !== 1'b0 || fe0 !== 1'b0) begin errs++; $display("FAIL midrst_next: got data=%h pe=%b fe=%b expected 5a 0 0", data0, pe0, fe0); end
        vectors++; if (dv0_n - b !== 1) begin errs++; $display("FAIL midrst_next_words: got %0d expected 1", dv0_n - b); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_false_start;
        test_parity;
        test_stop2;
        test_overrun;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
